// File: rtl/tx_pkg.sv
// Shared constants and types for the OFDM pilot insertion path.
// Holds the pilot FSM encodings, the pilot LFSR seed/taps and the pilot-position helper.
package tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_PILOT = 2'd2;

    localparam int         LFSR_W    = 7;
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    // x^7 + x^4 + 1: feedback is the XOR of state bits 6 and 3.
    localparam logic [6:0] LFSR_TAPS = 7'b100_1000;

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] mod;
        logic [3:0] ss;
    } sym_tags_t;

    function automatic logic is_pilot_pos(input int k, input int step);
        return (k % step) == (step - 1);
    endfunction

endpackage

// File: rtl/pilot_lfsr.sv
// Pilot sign generator: 7-bit Fibonacci LFSR, MSB out, reloadable to the seed.
// load has priority over step.
module pilot_lfsr
    import tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic out_bit
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LFSR_SEED;
        end else if (step) begin
            state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_bit = state_q[LFSR_W-1];

endmodule

// File: rtl/pilot_inserter.sv
// Inserts BPSK pilots every step_pilot subcarriers into a stream of mapped data samples,
// producing registered n_sub-sample OFDM symbols with sop/eos framing and captured tags.
module pilot_inserter
    import tx_pkg::*;
#(
    parameter int fft_depth   = 12,
    parameter int n_sub       = 64,
    parameter int step_pilot  = 8,
    parameter int level_pilot = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ival,
    input  logic                        isop,
    output logic                        iready,
    input  logic [1:0]                  index,
    input  logic [2:0]                  index_M_in,
    input  logic [3:0]                  index_SS_in,
    input  logic signed [fft_depth-1:0] sub_i,
    input  logic signed [fft_depth-1:0] sub_q,
    output logic                        oval,
    output logic                        osop,
    output logic                        oeos,
    output logic                        opilot,
    output logic [1:0]                  oindex,
    output logic [2:0]                  index_M_out,
    output logic [3:0]                  index_SS_out,
    output logic signed [fft_depth-1:0] osub_i,
    output logic signed [fft_depth-1:0] osub_q,
    output logic                        err,
    output logic [1:0]                  dbg_state
);

    localparam int                          POS_W     = (n_sub > 1) ? $clog2(n_sub) : 1;
    localparam logic [POS_W-1:0]            POS_LAST  = POS_W'(n_sub - 1);
    localparam logic signed [fft_depth-1:0] PILOT_POS = fft_depth'(level_pilot);
    localparam logic signed [fft_depth-1:0] PILOT_NEG = -PILOT_POS;

    logic [1:0]                  state_q, state_d;
    logic [POS_W-1:0]            pos_q, pos_d, pos_next;
    sym_tags_t                   tags_q, tags_d;
    logic                        oval_q, oval_d;
    logic                        osop_q, osop_d;
    logic                        oeos_q, oeos_d;
    logic                        opilot_q, opilot_d;
    logic                        err_q, err_d;
    logic signed [fft_depth-1:0] osub_i_q, osub_i_d;
    logic signed [fft_depth-1:0] osub_q_q, osub_q_d;
    logic                        start;
    logic                        lfsr_load, lfsr_step, lfsr_bit;

    pilot_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .out_bit (lfsr_bit)
    );

    // Handshake: a sample is consumed on a rising edge where ival && iready; iready
    // depends only on state (low during pilot cycles), and the output side has no backpressure.
    assign iready = (state_q != ST_PILOT);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        pos_next  = pos_q + POS_W'(1);
        tags_d    = tags_q;
        oval_d    = 1'b0;
        osop_d    = 1'b0;
        oeos_d    = 1'b0;
        opilot_d  = 1'b0;
        err_d     = 1'b0;
        osub_i_d  = '0;
        osub_q_d  = '0;
        start     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ival && isop) begin
                    start = 1'b1;
                end else if (ival) begin
                    err_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (ival && isop) begin
                    start = 1'b1;
                    err_d = 1'b1;
                end else if (ival) begin
                    oval_d   = 1'b1;
                    osub_i_d = sub_i;
                    osub_q_d = sub_q;
                    pos_d    = pos_next;
                    state_d  = is_pilot_pos(32'(pos_next), step_pilot) ? ST_PILOT : ST_DATA;
                end
            end
            ST_PILOT: begin
                oval_d    = 1'b1;
                opilot_d  = 1'b1;
                osub_i_d  = lfsr_bit ? PILOT_NEG : PILOT_POS;
                lfsr_step = 1'b1;
                if (pos_q == POS_LAST) begin
                    oeos_d  = 1'b1;
                    pos_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    pos_d   = pos_next;
                    state_d = is_pilot_pos(32'(pos_next), step_pilot) ? ST_PILOT : ST_DATA;
                end
            end
            default: begin
                pos_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A start from IDLE or a resync from DATA both open a fresh symbol at position 0.
        if (start) begin
            oval_d    = 1'b1;
            osop_d    = 1'b1;
            osub_i_d  = sub_i;
            osub_q_d  = sub_q;
            tags_d    = '{idx: index, mod: index_M_in, ss: index_SS_in};
            lfsr_load = 1'b1;
            pos_d     = POS_W'(1);
            state_d   = is_pilot_pos(1, step_pilot) ? ST_PILOT : ST_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            tags_q   <= '0;
            oval_q   <= 1'b0;
            osop_q   <= 1'b0;
            oeos_q   <= 1'b0;
            opilot_q <= 1'b0;
            err_q    <= 1'b0;
            osub_i_q <= '0;
            osub_q_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            tags_q   <= tags_d;
            oval_q   <= oval_d;
            osop_q   <= osop_d;
            oeos_q   <= oeos_d;
            opilot_q <= opilot_d;
            err_q    <= err_d;
            osub_i_q <= osub_i_d;
            osub_q_q <= osub_q_d;
        end
    end

    assign oval         = oval_q;
    assign osop         = osop_q;
    assign oeos         = oeos_q;
    assign opilot       = opilot_q;
    assign err          = err_q;
    assign osub_i       = osub_i_q;
    assign osub_q       = osub_q_q;
    assign oindex       = tags_q.idx;
    assign index_M_out  = tags_q.mod;
    assign index_SS_out = tags_q.ss;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pilot_inserter.sv
// Directed bench for pilot_inserter: a cycle-by-cycle vector table plus scoreboarded
// full-symbol sequences (contiguous, back-to-back, gapped, resync, mid-symbol reset).
module tb_pilot_inserter;
    import tx_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ival, isop, iready;
    logic [1:0]        index;
    logic [2:0]        index_M_in;
    logic [3:0]        index_SS_in;
    logic signed [11:0] sub_i, sub_q;
    logic              oval, osop, oeos, opilot, err;
    logic [1:0]        oindex;
    logic [2:0]        index_M_out;
    logic [3:0]        index_SS_out;
    logic signed [11:0] osub_i, osub_q;
    logic [1:0]        dbg_state;

    pilot_inserter dut (
        .clk          (clk),
        .rst          (rst),
        .ival         (ival),
        .isop         (isop),
        .iready       (iready),
        .index        (index),
        .index_M_in   (index_M_in),
        .index_SS_in  (index_SS_in),
        .sub_i        (sub_i),
        .sub_q        (sub_q),
        .oval         (oval),
        .osop         (osop),
        .oeos         (oeos),
        .opilot       (opilot),
        .oindex       (oindex),
        .index_M_out  (index_M_out),
        .index_SS_out (index_SS_out),
        .osub_i       (osub_i),
        .osub_q       (osub_q),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pilot sign per pilot slot (1 = negative), hand-stepped from seed 7'h7F.
    logic [7:0] pilot_neg = 8'b0111_1111;

    // Scoreboard record: {osop, oeos, opilot, osub_i, osub_q, oindex, M, SS}.
    logic [35:0] exp_q[$];
    bit          mon_en   = 1'b0;
    bit          b2b_en   = 1'b0;
    bit          have_eos = 1'b0;
    int          cyc      = 0;
    int          eos_cyc  = 0;
    int          err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [35:0] act, expv;
        cyc++;
        if (mon_en) begin
            if (err) err_seen++;
            if (oval) begin
                act = {osop, oeos, opilot, osub_i, osub_q, oindex, index_M_out, index_SS_out};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got %h expected nothing", act);
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        errors++;
                        $display("FAIL out_sample: got %h expected %h", act, expv);
                    end
                end
                if (b2b_en && osop && have_eos) begin
                    checks++;
                    if (cyc != eos_cyc + 1) begin
                        errors++;
                        $display("FAIL b2b_gap: got osop at cycle %0d expected %0d", cyc, eos_cyc + 1);
                    end
                end
                if (oeos) begin
                    have_eos = 1'b1;
                    eos_cyc  = cyc;
                end
            end
        end
    end

    task automatic set_tags(input logic [8:0] t);
        {index, index_M_in, index_SS_in} = t;
    endtask

    // Expected output of a symbol carrying ndata samples base, base+1, ...; partial
    // symbols stop right after their last data sample.
    task automatic push_symbol(input int base, input int ndata, input logic [8:0] tags);
        int j = 0;
        int p = 0;
        for (int pos = 0; pos < 64; pos++) begin
            if (pos % 8 == 7) begin
                if (j == ndata && ndata < 56) break;
                exp_q.push_back({1'b0, pos == 63, 1'b1,
                                 pilot_neg[p] ? -12'sd2000 : 12'sd2000, 12'd0, tags});
                p++;
            end else begin
                if (j == ndata) break;
                exp_q.push_back({pos == 0, 1'b0, 1'b0, 12'(base + j), 12'(-(base + j)), tags});
                j++;
            end
        end
    endtask

    task automatic drive_sample(input int d, input logic sop);
        int guard = 0;
        ival  = 1'b1;
        isop  = sop;
        sub_i = 12'(d);
        sub_q = 12'(-d);
        while (!iready && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!iready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got iready=0 expected 1 within 8 cycles");
        end
        @(posedge clk); #1;
        ival = 1'b0;
        isop = 1'b0;
    endtask

    task automatic drive_data(input int base, input int n, input logic [8:0] tags, input int max_gap);
        set_tags(tags);
        for (int k = 0; k < n; k++) begin
            drive_sample(base + k, k == 0);
            if (k == 0) set_tags(9'($urandom_range(0, 511)));
            if (max_gap > 0 && k < n - 1) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic send_symbol(input int base, input logic [8:0] tags, input int max_gap);
        push_symbol(base, 56, tags);
        drive_data(base, 56, tags, max_gap);
    endtask

    task automatic drain(input string name);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic        ival;
        logic        isop;
        logic [11:0] d;
        logic        exp_ready;
        logic        exp_oval;
        logic        exp_osop;
        logic        exp_opilot;
        logic        exp_err;
        logic [11:0] exp_i;
        logic [11:0] exp_q;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 12'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,      12'd0};
        vecs[1]  = '{1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,      12'd0};
        vecs[2]  = '{1'b1, 1'b1, 12'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1,      -12'd1};
        vecs[3]  = '{1'b1, 1'b0, 12'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd2,      -12'd2};
        vecs[4]  = '{1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,      12'd0};
        vecs[5]  = '{1'b1, 1'b0, 12'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3,      -12'd3};
        vecs[6]  = '{1'b1, 1'b0, 12'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd4,      -12'd4};
        vecs[7]  = '{1'b1, 1'b0, 12'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd5,      -12'd5};
        vecs[8]  = '{1'b1, 1'b0, 12'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd6,      -12'd6};
        vecs[9]  = '{1'b1, 1'b0, 12'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd7,      -12'd7};
        vecs[10] = '{1'b1, 1'b0, 12'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -12'd2000,  12'd0};
        vecs[11] = '{1'b1, 1'b0, 12'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd8,      -12'd8};
        vecs[12] = '{1'b1, 1'b1, 12'd50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd50,     -12'd50};

        rst = 1'b1;
        ival = 1'b0;
        isop = 1'b0;
        sub_i = '0;
        sub_q = '0;
        set_tags(9'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({oval, osop, oeos, opilot, err, oindex, index_M_out,
                                    index_SS_out, osub_i, osub_q}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        check("reset_iready", 64'(iready), 64'd1);

        for (int v = 0; v < 13; v++) begin
            logic ready_pre;
            ival  = vecs[v].ival;
            isop  = vecs[v].isop;
            sub_i = vecs[v].d;
            sub_q = 12'(-vecs[v].d);
            ready_pre = iready;
            @(posedge clk); #1;
            check($sformatf("vec%0d", v),
                  64'({ready_pre, oval, osop, opilot, err, osub_i, osub_q}),
                  64'({vecs[v].exp_ready, vecs[v].exp_oval, vecs[v].exp_osop, vecs[v].exp_opilot,
                       vecs[v].exp_err, vecs[v].exp_i, vecs[v].exp_q}));
        end
        ival = 1'b0;
        isop = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // Two contiguous symbols back-to-back; pilot signs repeat in the second.
        b2b_en = 1'b1;
        send_symbol(1, {2'd1, 3'd3, 4'd7}, 0);
        send_symbol(101, {2'd2, 3'd6, 4'd12}, 0);
        drain("b2b_drain");
        b2b_en = 1'b0;
        check("b2b_seen_eos", 64'(have_eos), 64'd1);

        send_symbol(600, {2'd3, 3'd1, 4'd5}, 3);
        drain("gap_drain");

        // Resync: isop on data sample 20 opens a new symbol with new tags.
        err_seen = 0;
        push_symbol(200, 20, {2'd0, 3'd2, 4'd9});
        drive_data(200, 20, {2'd0, 3'd2, 4'd9}, 0);
        send_symbol(300, {2'd1, 3'd4, 4'd14}, 0);
        drain("resync_drain");
        check("resync_err_count", 64'(err_seen), 64'd1);

        // Reset while the data sample at position 30 is on the outputs.
        push_symbol(400, 28, {2'd2, 3'd7, 4'd3});
        drive_data(400, 28, {2'd2, 3'd7, 4'd3}, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", 64'({oval, osop, oeos, opilot, err, oindex, index_M_out,
                                       index_SS_out, osub_i, osub_q}), 64'd0);
        check("midreset_state", 64'(dbg_state), 64'(ST_IDLE));
        #1;
        rst = 1'b0;
        check("midreset_iready", 64'(iready), 64'd1);
        check("midreset_flushed", 64'(exp_q.size()), 64'd0);
        send_symbol(500, {2'd3, 3'd5, 4'd10}, 0);
        drain("postreset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
